// File: rtl/aurora_tx_arbiter_pkg.sv
// Shared encodings for the Aurora TX arbiter: FSM states, grant/rr codes, close-beat keep.
package aurora_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PASS  = 2'd1,
      ST_CLOSE = 2'd2,
      ST_DROP  = 2'd3
   } state_t;

   localparam logic [3:0] C_PAD_KEEP   = 4'b1000;

   localparam logic [1:0] C_GRANT_NONE = 2'b00;
   localparam logic [1:0] C_GRANT_S0   = 2'b01;
   localparam logic [1:0] C_GRANT_S1   = 2'b10;

   // The rr pointer remembers who was served last; the reset value favours s0.
   localparam logic       C_RR_LAST_S1 = 1'b0;
   localparam logic       C_RR_LAST_S0 = 1'b1;

   function automatic logic [1:0] f_rr_pick(input logic i_v0, input logic i_v1, input logic i_rr_last);
      if (i_v0 && i_v1)
         return (i_rr_last == C_RR_LAST_S0) ? C_GRANT_S1 : C_GRANT_S0;
      else if (i_v0)
         return C_GRANT_S0;
      else if (i_v1)
         return C_GRANT_S1;
      return C_GRANT_NONE;
   endfunction

endpackage

// File: rtl/aurora_tx_arbiter_if.sv
// AXI-stream bundle used for both requester inputs and the Aurora TX output.
interface aurora_tx_arbiter_if #(
   parameter int P_DATA_W = 32,
   parameter int P_KEEP_W = 4
);
   logic [P_DATA_W-1:0] tdata;
   logic [P_KEEP_W-1:0] tkeep;
   logic                tlast;
   logic                tvalid;
   logic                tready;

   modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
   modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/aurora_tx_arbiter_sat_counter.sv
// Statistics counter that increments on request and sticks at all-ones.
module sat_counter #(
   parameter int P_W = 16
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_inc,
   output logic [P_W-1:0] o_cnt
);
   logic [P_W-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_cnt <= '0;
      else if (i_inc && (r_cnt != '1))
         r_cnt <= r_cnt + 1'b1;
   end

   assign o_cnt = r_cnt;
endmodule

// File: rtl/aurora_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one Aurora TX stream between s0 (camera) and s1 (control).
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no owner; grant on channel_up when a requester is valid
// ST_PASS  | granted source passed through until its tlast transfers
// ST_CLOSE | source stalled too long; emit one pad beat with tlast
// ST_DROP  | packet abandoned; sink the rest of it up to its tlast
module aurora_tx_arbiter
   import aurora_pkg::*;
#(
   parameter int P_DATA_W  = 32,
   parameter int P_KEEP_W  = 4,
   parameter int P_TIMEOUT = 4096,
   parameter int P_CNT_W   = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_channel_up,
   aurora_tx_arbiter_if.slave   s0_axi,
   aurora_tx_arbiter_if.slave   s1_axi,
   aurora_tx_arbiter_if.master  m_axi,
   output logic [1:0]           o_grant,
   output logic                 o_timeout_err,
   output logic [P_CNT_W-1:0]   o_pkt_cnt0,
   output logic [P_CNT_W-1:0]   o_pkt_cnt1,
   output logic [P_CNT_W-1:0]   o_drop_cnt
);
   localparam int LP_TMO_W = (P_TIMEOUT > 2) ? $clog2(P_TIMEOUT) : 1;
   localparam logic [P_KEEP_W-1:0] LP_PAD_KEEP = (P_KEEP_W == 4) ? P_KEEP_W'(C_PAD_KEEP)
                                                                : (P_KEEP_W'(1) << (P_KEEP_W - 1));

   state_t               r_state, w_state_nxt;
   logic [1:0]           r_grant, w_grant_nxt;
   logic                 r_rr, w_rr_nxt;
   logic [LP_TMO_W-1:0]  r_tmo_cnt;
   logic                 r_timeout_err, w_timeout;
   logic                 w_inc_pkt0, w_inc_pkt1, w_inc_drop;

   logic                 w_sel1;
   logic [P_DATA_W-1:0]  w_g_tdata;
   logic [P_KEEP_W-1:0]  w_g_tkeep;
   logic                 w_g_tlast, w_g_tvalid, w_g_tready;
   logic                 w_tmo_tc, w_rr_owner;

   assign w_sel1     = (r_grant == C_GRANT_S1);
   assign w_g_tdata  = w_sel1 ? s1_axi.tdata  : s0_axi.tdata;
   assign w_g_tkeep  = w_sel1 ? s1_axi.tkeep  : s0_axi.tkeep;
   assign w_g_tlast  = w_sel1 ? s1_axi.tlast  : s0_axi.tlast;
   assign w_g_tvalid = w_sel1 ? s1_axi.tvalid : s0_axi.tvalid;
   assign w_tmo_tc   = (r_tmo_cnt == LP_TMO_W'(P_TIMEOUT - 1));
   assign w_rr_owner = w_sel1 ? C_RR_LAST_S1 : C_RR_LAST_S0;

   always_comb begin
      w_state_nxt  = r_state;
      w_grant_nxt  = r_grant;
      w_rr_nxt     = r_rr;
      w_timeout    = 1'b0;
      w_inc_pkt0   = 1'b0;
      w_inc_pkt1   = 1'b0;
      w_inc_drop   = 1'b0;
      w_g_tready   = 1'b0;
      m_axi.tdata  = '0;
      m_axi.tkeep  = '0;
      m_axi.tlast  = 1'b0;
      m_axi.tvalid = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (i_channel_up && (s0_axi.tvalid || s1_axi.tvalid)) begin
               w_grant_nxt = f_rr_pick(s0_axi.tvalid, s1_axi.tvalid, r_rr);
               w_state_nxt = ST_PASS;
            end
         end
         ST_PASS: begin
            m_axi.tdata  = w_g_tdata;
            m_axi.tkeep  = w_g_tkeep;
            m_axi.tlast  = w_g_tlast;
            m_axi.tvalid = w_g_tvalid;
            w_g_tready   = m_axi.tready;
            // A tlast beat moving in the same cycle the link falls still completes the packet.
            if (w_g_tvalid && m_axi.tready && w_g_tlast) begin
               w_state_nxt = ST_IDLE;
               w_grant_nxt = C_GRANT_NONE;
               w_rr_nxt    = w_rr_owner;
               w_inc_pkt0  = !w_sel1;
               w_inc_pkt1  = w_sel1;
            end else if (!i_channel_up) begin
               w_state_nxt = ST_DROP;
               w_inc_drop  = 1'b1;
            end else if (!w_g_tvalid && w_tmo_tc) begin
               w_state_nxt = ST_CLOSE;
               w_timeout   = 1'b1;
            end
         end
         ST_CLOSE: begin
            m_axi.tkeep  = LP_PAD_KEEP;
            m_axi.tlast  = 1'b1;
            m_axi.tvalid = i_channel_up;
            if (!i_channel_up || m_axi.tready) begin
               w_state_nxt = ST_DROP;
               w_inc_drop  = 1'b1;
            end
         end
         ST_DROP: begin
            w_g_tready = 1'b1;
            if (w_g_tvalid && w_g_tlast) begin
               w_state_nxt = ST_IDLE;
               w_grant_nxt = C_GRANT_NONE;
               w_rr_nxt    = w_rr_owner;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = C_GRANT_NONE;
         end
      endcase

      s0_axi.tready = w_g_tready && (r_grant == C_GRANT_S0);
      s1_axi.tready = w_g_tready && (r_grant == C_GRANT_S1);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= ST_IDLE;
         r_grant       <= C_GRANT_NONE;
         r_rr          <= C_RR_LAST_S1;
         r_tmo_cnt     <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_grant       <= w_grant_nxt;
         r_rr          <= w_rr_nxt;
         r_timeout_err <= w_timeout;
         if ((r_state == ST_PASS) && !w_g_tvalid && !w_tmo_tc)
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
         else
            r_tmo_cnt <= '0;
      end
   end

   sat_counter #(.P_W(P_CNT_W)) u_cnt_pkt0 (.i_clk(i_clk), .i_rst(i_rst), .i_inc(w_inc_pkt0), .o_cnt(o_pkt_cnt0));
   sat_counter #(.P_W(P_CNT_W)) u_cnt_pkt1 (.i_clk(i_clk), .i_rst(i_rst), .i_inc(w_inc_pkt1), .o_cnt(o_pkt_cnt1));
   sat_counter #(.P_W(P_CNT_W)) u_cnt_drop (.i_clk(i_clk), .i_rst(i_rst), .i_inc(w_inc_drop), .o_cnt(o_drop_cnt));

   assign o_grant       = r_grant;
   assign o_timeout_err = r_timeout_err;
endmodule

// File: doc/aurora_tx_arbiter.md
Name: aurora_tx_arbiter

Overview:
Packet-level round-robin arbiter that shares one Aurora channel TX AXI-stream (c0 user side) between two requesters: camera packet stream (s0) and control/status stream (s1).
- Lives in the Aurora user_clk domain, between the requesters and the aurora_module s_axi_c0_tx_* port.
- Holds each grant for a whole packet (until tlast). Gates traffic on channel_up.
- Closes and drops packets whose source stalls or whose link drops mid-packet, so Aurora framing is never left open.

Parameters:
P_DATA_W, 32, tdata width
P_KEEP_W, 4, tkeep width (P_DATA_W/8)
P_TIMEOUT, 4096, idle cycles of granted source mid-packet before forced close
P_CNT_W, 16, width of statistics counters

Ports:
i_clk  in  1  Aurora user clock
i_rst  in  1  asynchronous reset, active-high
i_channel_up  in  1  Aurora channel_up, synchronous to i_clk
s0_axi_tdata/tkeep/tlast/tvalid  in  P_DATA_W/P_KEEP_W/1/1  requester 0 (camera)
s0_axi_tready  out  1  requester 0 ready
s1_axi_tdata/tkeep/tlast/tvalid  in  P_DATA_W/P_KEEP_W/1/1  requester 1 (control)
s1_axi_tready  out  1  requester 1 ready
m_axi_tdata/tkeep/tlast/tvalid  out  P_DATA_W/P_KEEP_W/1/1  to Aurora TX
m_axi_tready  in  1  Aurora TX ready
o_grant  out  2  one-hot current owner, 00 = none
o_timeout_err  out  1  one-cycle pulse on forced close
o_pkt_cnt0  out  P_CNT_W  packets from s0 fully forwarded
o_pkt_cnt1  out  P_CNT_W  packets from s1 fully forwarded
o_drop_cnt  out  P_CNT_W  packets truncated or dropped

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE, o_grant=00, rr pointer=0 (s0 favoured first).
  - All counters=0, o_timeout_err=0.
  - m_axi_tvalid=0, both s_tready=0.
  - Reset mid-packet abandons the packet; no close beat is emitted.
- States: IDLE, PASS, CLOSE, DROP.
- IDLE:
  - Outputs idle.
  - If i_channel_up=1 and any s_tvalid=1: register grant next cycle and go to PASS.
  - Both valid: grant the requester not served last (rr pointer). One valid: grant it.
- PASS, combinational pass-through of the granted source:
  - m_axi_* = granted s_axi_*; granted s_tready = m_axi_tready; other s_tready=0.
  - Beat transfers when m_axi_tvalid & m_axi_tready.
  - Transfer with tlast: go to IDLE, increment that requester's pkt_cnt, set rr pointer to that requester.
  - Result: at least one idle cycle between packets; single-beat packets are legal.
- Timeout:
  - In PASS, a counter increments each cycle the granted s_tvalid=0, and clears on any granted s_tvalid=1.
  - Reaching P_TIMEOUT-1: go to CLOSE, pulse o_timeout_err.
- CLOSE:
  - Drive one pad beat: m_axi_tdata=0, tkeep=MSB-only (4'b1000), tlast=1, tvalid=1. Both s_tready=0.
  - On m_axi_tready: increment o_drop_cnt, go to DROP.
- DROP:
  - m_axi_tvalid=0; granted s_tready=1 (sink).
  - Accepted beat with tlast: go to IDLE, rr pointer := dropped requester.
- Link loss:
  - i_channel_up=0 in PASS: go to DROP next cycle, increment o_drop_cnt, emit no close beat (link down), no timeout pulse.
  - Beat transferring in the same cycle as the fall is still counted as transferred.
  - If that beat carried tlast: go to IDLE, counted as forwarded, no drop.
- i_channel_up=0 in IDLE: no grant.
- i_channel_up=0 in CLOSE: abandon close beat, go to DROP, increment o_drop_cnt once.
- Counters saturate at all-ones.
- o_grant stays one-hot through PASS/CLOSE/DROP; 00 in IDLE.

Decomposition:
- Shared package aurora_pkg: state encoding constants, the pad keep value 4'b1000, and the rr/grant encodings.
- One natural sub-module, sat_counter (parameterised width, inc, saturate), instantiated three times.
- Everything else stays in aurora_tx_arbiter.

Test Plan:
- Both requesters present 4-beat packets continuously, m_tready=1 -> output alternates s0,s1,s0,s1; o_pkt_cnt0=o_pkt_cnt1=2 after 4 packets; one idle cycle between packets.
- s0 single-beat packet with m_tready toggling 1010 -> beat held stable while tready=0, transfers once; o_pkt_cnt0=1.
- s1 sends 2 beats then stalls tvalid=0 for P_TIMEOUT cycles (override P_TIMEOUT=16) -> o_timeout_err one pulse; pad beat data=0, keep=1000, tlast=1; remaining s1 beats sunk with tready=1; o_drop_cnt=1; no m_tvalid during DROP.
- i_channel_up falls on beat 3 of 8-beat s0 packet -> no further m_tvalid; s0 drained to tlast; o_drop_cnt=1; next grant goes to s1 if pending.
- i_channel_up=0 at start with both valid -> o_grant stays 00; raise channel_up -> s0 granted first after reset.
- Assert i_rst mid-PASS -> asynchronously m_tvalid=0, o_grant=00, all counters 0.
